// File: rtl/bank_port_ctrl_if.sv
// Bundle of requester, arbiter and bank signals for one bank port controller.
// slave: the controller's view. master: the surrounding requesters/arbiter/bank.
interface bank_port_ctrl_if #(
   parameter int N  = 5,
   parameter int AW = 8,
   parameter int DW = 32
);
   logic [N-1:0]    req_i;
   logic [N*AW-1:0] addr_i;
   logic [N*DW-1:0] wdata_i;
   logic [N-1:0]    we_i;
   logic [N-1:0]    arb_req;
   logic [N-1:0]    arb_grant;
   logic            bank_en;
   logic            bank_we;
   logic [AW-1:0]   bank_addr;
   logic [DW-1:0]   bank_wdata;
   logic [DW-1:0]   bank_rdata;
   logic [N-1:0]    ack;
   logic [DW-1:0]   rdata;
   logic            busy;

   modport slave (
      input  req_i, addr_i, wdata_i, we_i, arb_grant, bank_rdata,
      output arb_req, bank_en, bank_we, bank_addr, bank_wdata, ack, rdata, busy
   );

   modport master (
      output req_i, addr_i, wdata_i, we_i, arb_grant, bank_rdata,
      input  arb_req, bank_en, bank_we, bank_addr, bank_wdata, ack, rdata, busy
   );
endinterface

// File: rtl/bank_port_ctrl.sv
// Per-bank transaction controller behind the round-robin arbiter.
// Takes a one-hot grant, drives one single-port bank with LAT-cycle read
// latency, and returns a one-cycle ack plus read data to the winner.
// Optional macro BANK_FAST_WRITE_EN: writes skip the read-latency wait.
module bank_port_ctrl #(
   parameter int N   = 5,
   parameter int AW  = 8,
   parameter int DW  = 32,
   parameter int LAT = 2
) (
   input logic             clk,
   input logic             rst,
   bank_port_ctrl_if.slave bus
);
   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam int CW = $clog2(LAT + 1);
   localparam logic [N-1:0]  ONE_N   = N'(1);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);
   localparam logic [CW-1:0] CNT_LAT = CW'(LAT);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t         state_q, state_d;
   logic [IW-1:0]  idx_q, idx_d;
   logic [AW-1:0]  addr_q, addr_d;
   logic [DW-1:0]  wdata_q, wdata_d;
   logic           we_q, we_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [DW-1:0]  rdata_q, rdata_d;
   logic [N-1:0]   served_q, served_d;

   logic [N-1:0]   arb_req_w;
   logic [N-1:0]   idx_onehot;
   logic [IW-1:0]  grant_idx;
   logic           grant_ok;

   assign arb_req_w  = (state_q == IDLE) ? (bus.req_i & ~served_q) : '0;
   assign idx_onehot = ONE_N << idx_q;

   // Decode the grant: position of its bit, and whether it is a legal one-hot
   // grant of a requester we are actually presenting.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      grant_idx = '0;
      for (int i = 0; i < N; i++) begin
         if (bus.arb_grant[i]) grant_idx = IW'(i);
      end
      grant_ok = (bus.arb_grant != '0)
              && ((bus.arb_grant & (bus.arb_grant - ONE_N)) == '0)
              && ((bus.arb_grant & ~arb_req_w) == '0);
   end

   // Next-state and datapath update for the IDLE/ISSUE/WAIT/RESP sequence.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      we_d     = we_q;
      cnt_d    = cnt_q;
      rdata_d  = rdata_q;
      served_d = served_q;
      unique case (state_q)
         IDLE: begin
            // The served bit only needs to survive one IDLE cycle.
            served_d = '0;
            if (grant_ok) begin
               idx_d   = grant_idx;
               addr_d  = bus.addr_i[int'(grant_idx)*AW +: AW];
               wdata_d = bus.wdata_i[int'(grant_idx)*DW +: DW];
               we_d    = bus.we_i[grant_idx];
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            cnt_d   = CNT_LAT;
            state_d = WAIT;
`ifdef BANK_FAST_WRITE_EN
            if (we_q) begin
               rdata_d = '0;
               state_d = RESP;
            end
`endif
         end
         WAIT: begin
            if (cnt_q == CNT_ONE) begin
               rdata_d = we_q ? '0 : bus.bank_rdata;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         RESP: begin
            // Mask the requester just acked so it cannot win again before it drops req.
            served_d = idx_onehot;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and command registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         // NOTE: every register here is reset; an in-flight transaction is simply abandoned.
         state_q  <= IDLE;
         idx_q    <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         we_q     <= 1'b0;
         cnt_q    <= '0;
         rdata_q  <= '0;
         served_q <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         we_q     <= we_d;
         cnt_q    <= cnt_d;
         rdata_q  <= rdata_d;
         served_q <= served_d;
      end
   end

   // The latched command only changes when entering ISSUE, so the bank
   // address/data/we hold their last values outside ISSUE for free.
   assign bus.arb_req    = arb_req_w;
   assign bus.bank_en    = (state_q == ISSUE);
   assign bus.bank_we    = we_q;
   assign bus.bank_addr  = addr_q;
   assign bus.bank_wdata = wdata_q;
   assign bus.ack        = (state_q == RESP) ? idx_onehot : '0;
   assign bus.rdata      = rdata_q;
   assign bus.busy       = (state_q != IDLE);
endmodule

// File: doc/bank_port_ctrl.md
Name: bank_port_ctrl

Overview:
- Per-bank transaction controller that sits directly downstream of the round-robin arbiter in the multi-bank memory.
- Presents the gated requester vector to the arbiter and consumes the one-hot grant.
- Latches the winning requester's command and drives one single-port memory bank with fixed read latency.
- Returns read data and a one-cycle ack to the originating requester, holding off further arbitration while a transaction is in flight.

Parameters:
- N, 5, number of requesters; must match the arbiter's N.
- AW, 8, bank address width.
- DW, 32, data width.
- LAT, 2, bank read latency in cycles; minimum 1.

Ports:
- clk  in  1  clock; all state on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_i  in  N  per-requester request; held high until that requester's ack.
- addr_i  in  N*AW  per-requester address; requester i occupies bits [i*AW +: AW].
- wdata_i  in  N*DW  per-requester write data; slice i as above.
- we_i  in  N  per-requester write enable (1 = write, 0 = read).
- arb_req  out  N  request vector driven to the arbiter.
- arb_grant  in  N  one-hot grant from the arbiter; combinational from arb_req.
- bank_en  out  1  bank access strobe.
- bank_we  out  1  bank write enable.
- bank_addr  out  AW  bank address.
- bank_wdata  out  DW  bank write data.
- bank_rdata  in  DW  bank read data; valid in the cycle LAT cycles after the bank_en cycle.
- ack  out  N  one-cycle completion pulse to the owning requester.
- rdata  out  DW  read data; valid while any ack bit is high.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset values: state IDLE; ack=0, rdata=0, bank_en=0, bank_we=0, bank_addr=0, bank_wdata=0, busy=0, served mask=0, latched index/command=0.
- Async reset mid-transaction aborts it immediately. No ack is issued. bank_en drops without waiting for a clock edge.
- arb_req = req_i & ~served_mask in IDLE; 0 in every other state.
- served_mask:
  - Set to the acked requester's bit on the RESP->IDLE transition.
  - Cleared after exactly one IDLE cycle.
  - Purpose: the requester is not re-granted before it can drop req.
- IDLE:
  - If arb_grant != 0, latch index i (position of the grant bit) plus addr_i[i], wdata_i[i], we_i[i] at the clock edge, and go to ISSUE.
  - If arb_grant is not one-hot, or its set bit is not in arb_req, the grant is ignored and state stays IDLE.
- ISSUE (1 cycle):
  - bank_en=1; bank_we, bank_addr, bank_wdata driven from the latched command.
  - Load the wait counter with LAT, then go to WAIT.
- WAIT (LAT cycles):
  - bank_en=0; counter decrements each cycle.
  - In the final WAIT cycle (counter==1), capture bank_rdata into the rdata register and go to RESP.
  - Writes also pass through WAIT; the captured data is don't-care and rdata is forced to 0 for writes.
- RESP (1 cycle): ack[i]=1, rdata holds the captured value; go to IDLE.
- Latency:
  - Grant sampled at the end of cycle t: bank_en in t+1, ack in t+2+LAT.
  - Example, LAT=2: grant in cycle 0, ack in cycle 4.
  - Back-to-back grants: earliest next grant is the IDLE cycle t+3+LAT.
- Bank outputs other than bank_en keep their last values outside ISSUE. bank_en is high only in ISSUE.
- At most one transaction is outstanding. Requests arriving while busy wait, held on req_i.
- Counter width: $clog2(LAT+1).

Optional Feature:
- Macro: BANK_FAST_WRITE_EN.
- Defined: a write skips WAIT, so ISSUE goes straight to RESP. Write latency is grant+2 cycles (grant cycle t, ack t+2). Reads are unchanged.
- Undefined: writes follow the same LAT-cycle path as reads (ack at t+2+LAT).

Test Plan:
- Single read, LAT=2: req_i=5'b00100, addr=0x12, bank returns 0xDEADBEEF in cycle 3 -> bank_en only in cycle 1 with bank_addr=0x12; ack=5'b00100 and rdata=0xDEADBEEF in cycle 4 only.
- Single write: req 1, addr 0x05, wdata 0xA5A5A5A5, we=1 -> bank_en=bank_we=1 in cycle 1 with that data; ack[1] in cycle 4, or cycle 2 with BANK_FAST_WRITE_EN; rdata=0.
- All 5 requesters held high -> acks issued in round-robin order 0,1,2,3,4, each LAT+3 cycles apart; arb_req=0 while busy.
- Served masking: requester 0 keeps req high one cycle after its ack alongside requester 3 -> next grant goes to requester 3, never back-to-back to 0.
- Async reset asserted in WAIT mid-read -> ack, bank_en and busy drop without a clock edge; no ack after release; a new request completes normally.
- Illegal grant 5'b00110 injected in IDLE -> ignored, bank_en stays 0, state stays IDLE.
